// File: rtl/adiabatic_pclk_sequencer.sv
// Power-clock sequencer: staggered trapezoidal ramp codes for N_PHASE adiabatic phases,
// with a run/stop handshake that drains every started phase back to idle.
module adiabatic_pclk_sequencer #(
    parameter int unsigned N_PHASE   = 4,
    parameter int unsigned CODE_W    = 8,
    parameter int unsigned RAMP_LOG2 = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run_req_i,
    output logic                      run_ack_o,
    output logic                      busy_o,
    output logic [N_PHASE*CODE_W-1:0] clkpos_code_o,
    output logic [N_PHASE*CODE_W-1:0] clkneg_code_o,
    output logic [N_PHASE-1:0]        phase_active_o,
    output logic [N_PHASE-1:0]        eval_strobe_o
);
    localparam int unsigned ProdW = CODE_W + RAMP_LOG2;

    localparam logic [1:0] StOff   = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    localparam logic [RAMP_LOG2-1:0] CLast  = '1;
    localparam logic [ProdW-1:0]     MaxExt = {{RAMP_LOG2{1'b0}}, {CODE_W{1'b1}}};

    logic [1:0]                state_q, state_d;
    logic [1:0]                q_q, q_d;
    logic [RAMP_LOG2-1:0]      c_q, c_d;
    logic [N_PHASE-1:0]        active_q, active_d;
    logic [N_PHASE*CODE_W-1:0] code_q, code_d;
    logic [N_PHASE-1:0]        strobe_q, strobe_d;
    logic [1:0]                lq;
    logic [ProdW-1:0]          prod;

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        c_d      = '0;
        active_d = active_q;
        if (state_q != StOff) begin
            c_d = c_q + 1'b1;
            if (c_q == CLast) begin
                q_d = q_q + 2'd1;
            end
        end
        unique case (state_q)
            StOff: begin
                if (run_req_i) begin
                    q_d         = '0;
                    active_d    = '0;
                    active_d[0] = 1'b1;
                    state_d     = (N_PHASE == 1) ? StRun : StStart;
                end
            end
            StStart: begin
                if (!run_req_i) begin
                    state_d = StDrain;
                end else begin
                    // Phase i joins on the wrap edge where the quarter count reaches i.
                    for (int unsigned i = 1; i < N_PHASE; i++) begin
                        if (c_d == '0 && q_d == 2'(i)) begin
                            active_d[i] = 1'b1;
                        end
                    end
                    if (active_d[N_PHASE-1]) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!run_req_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // A phase retires only on the edge it enters its idle quarter.
                for (int unsigned i = 0; i < N_PHASE; i++) begin
                    if (c_d == '0 && (q_d - 2'(i)) == 2'd3) begin
                        active_d[i] = 1'b0;
                    end
                end
                if (active_d == '0) begin
                    state_d = StOff;
                    q_d     = '0;
                    c_d     = '0;
                end
            end
        endcase
    end

    // Codes and strobes are derived from next-state counters so they land on the same edge.
    always_comb begin
        code_d   = '0;
        strobe_d = '0;
        lq       = '0;
        prod     = '0;
        for (int unsigned i = 0; i < N_PHASE; i++) begin
            lq   = q_d - 2'(i);
            prod = '0;
            if (active_d[i]) begin
                unique case (lq)
                    2'd0:    prod = ({{CODE_W{1'b0}}, c_d} + ProdW'(1)) * MaxExt;
                    2'd1:    prod = MaxExt << RAMP_LOG2;
                    2'd2:    prod = {{CODE_W{1'b0}}, CLast - c_d} * MaxExt;
                    default: prod = '0;
                endcase
                strobe_d[i] = (lq == 2'd1) && (c_d == '0);
            end
            code_d[i*CODE_W +: CODE_W] = prod[ProdW-1:RAMP_LOG2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StOff;
            q_q      <= '0;
            c_q      <= '0;
            active_q <= '0;
            code_q   <= '0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            c_q      <= c_d;
            active_q <= active_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
        end
    end

    assign run_ack_o      = (state_q == StRun);
    assign busy_o         = (state_q != StOff);
    assign clkpos_code_o  = code_q;
    assign clkneg_code_o  = ~code_q;
    assign phase_active_o = active_q;
    assign eval_strobe_o  = strobe_q;

endmodule

// File: tb/tb_adiabatic_pclk_sequencer.sv
// Bench for adiabatic_pclk_sequencer: fixed timing table, hand-written corner sequences,
// and randomized run/stop traffic against a time-based reference model.
module tb_adiabatic_pclk_sequencer;
    localparam int NP   = 4;
    localparam int CW   = 8;
    localparam int RC   = 8;
    localparam int MAXV = 255;
    localparam int PER  = 4 * RC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run_req = 1'b0;
    logic        run_ack;
    logic        busy;
    logic [31:0] pos;
    logic [31:0] neg;
    logic [3:0]  act;
    logic [3:0]  strb;

    int checks   = 0;
    int failures = 0;

    adiabatic_pclk_sequencer #(
        .N_PHASE  (NP),
        .CODE_W   (CW),
        .RAMP_LOG2(3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_req_i     (run_req),
        .run_ack_o     (run_ack),
        .busy_o        (busy),
        .clkpos_code_o (pos),
        .clkneg_code_o (neg),
        .phase_active_o(act),
        .eval_strobe_o (strb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic       req;
        logic [7:0] c0, c1, c2, c3;
        logic [3:0] act;
        logic       ack;
        logic       busy;
        logic [3:0] strb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, actual, required, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int e, input logic r, input logic [7:0] a0, a1, a2, a3,
                           input logic [3:0] ac, input logic ak, bs, input logic [3:0] sb);
        vec_t v;
        v.edge_n = e; v.req = r;
        v.c0 = a0; v.c1 = a1; v.c2 = a2; v.c3 = a3;
        v.act = ac; v.ack = ak; v.busy = bs; v.strb = sb;
        vecs.push_back(v);
    endtask

    // Reference model: time since start drives every phase's position in its trapezoid.
    int       m_t;
    bit       m_busy;
    bit       m_drain;
    bit [3:0] m_act;

    task automatic model_reset();
        m_t = 0; m_busy = 0; m_drain = 0; m_act = '0;
    endtask

    function automatic int m_tl(input int i);
        return (((m_t - RC * i) % PER) + PER) % PER;
    endfunction

    function automatic logic [7:0] m_code(input int i);
        int tl;
        int cc;
        if (!m_busy || !m_act[i]) return 8'd0;
        tl = m_tl(i);
        cc = tl % RC;
        case (tl / RC)
            0:       return 8'(((cc + 1) * MAXV) / RC);
            1:       return 8'(MAXV);
            2:       return 8'(((RC - 1 - cc) * MAXV) / RC);
            default: return 8'd0;
        endcase
    endfunction

    task automatic model_step(input bit req);
        if (!m_busy) begin
            if (req) begin
                m_busy = 1; m_drain = 0; m_t = 0; m_act = 4'b0001;
            end
        end else begin
            m_t++;
            if (!m_drain) begin
                if (!req) m_drain = 1;
                else for (int i = 1; i < NP; i++) if (m_t == RC * i) m_act[i] = 1'b1;
            end else begin
                for (int i = 0; i < NP; i++) if (m_act[i] && m_tl(i) == 3 * RC) m_act[i] = 1'b0;
                if (m_act == 0) m_busy = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ep;
        logic [3:0]  es;
        for (int i = 0; i < NP; i++) begin
            ep[i*CW +: CW] = m_code(i);
            es[i] = m_busy && m_act[i] && (m_tl(i) == RC);
        end
        check({tag, "_pos"}, pos, ep);
        check({tag, "_neg"}, neg, ~ep);
        check({tag, "_act"}, {28'd0, act}, {28'd0, m_act});
        check({tag, "_strb"}, {28'd0, strb}, {28'd0, es});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, m_busy});
        check({tag, "_ack"}, {31'd0, run_ack}, {31'd0, m_busy && !m_drain && (&m_act)});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int idx;
        int len;
        bit req;

        #2 rst_n = 1'b0;
        #1;
        check("rst_pos", pos, 32'h0);
        check("rst_neg", neg, 32'hffff_ffff);
        check("rst_flags", {26'd0, run_ack, busy, act}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_pos", pos, 32'h0);
        check("idle_flags", {22'd0, run_ack, busy, act, strb}, 32'h0);

        // Start, steady run and drain timing from a fixed table.
        add_vec(0,  1, 31,  0,   0,   0,   4'b0001, 0, 1, 4'b0000);
        add_vec(5,  1, 191, 0,   0,   0,   4'b0001, 0, 1, 4'b0000);
        add_vec(7,  1, 255, 0,   0,   0,   4'b0001, 0, 1, 4'b0000);
        add_vec(8,  1, 255, 31,  0,   0,   4'b0011, 0, 1, 4'b0001);
        add_vec(9,  1, 255, 63,  0,   0,   4'b0011, 0, 1, 4'b0000);
        add_vec(16, 1, 223, 255, 31,  0,   4'b0111, 0, 1, 4'b0010);
        add_vec(23, 1, 0,   255, 255, 0,   4'b0111, 0, 1, 4'b0000);
        add_vec(24, 1, 0,   223, 255, 31,  4'b1111, 1, 1, 4'b0100);
        add_vec(31, 1, 0,   0,   255, 255, 4'b1111, 1, 1, 4'b0000);
        add_vec(32, 1, 31,  0,   223, 255, 4'b1111, 1, 1, 4'b1000);
        add_vec(40, 0, 255, 31,  0,   223, 4'b1111, 0, 1, 4'b0001);
        add_vec(48, 0, 223, 255, 31,  0,   4'b0111, 0, 1, 4'b0010);
        add_vec(56, 0, 0,   223, 255, 0,   4'b0110, 0, 1, 4'b0100);
        add_vec(64, 0, 0,   0,   223, 0,   4'b0100, 0, 1, 4'b0000);
        add_vec(71, 0, 0,   0,   0,   0,   4'b0100, 0, 1, 4'b0000);
        add_vec(72, 0, 0,   0,   0,   0,   4'b0000, 0, 0, 4'b0000);
        add_vec(73, 0, 0,   0,   0,   0,   4'b0000, 0, 0, 4'b0000);

        idx = 0;
        for (int e = 0; e <= 73; e++) begin
            if (idx < vecs.size() && vecs[idx].edge_n == e) run_req = vecs[idx].req;
            tick();
            if (idx < vecs.size() && vecs[idx].edge_n == e) begin
                check($sformatf("vec_E%0d_pos", e), pos,
                      {vecs[idx].c3, vecs[idx].c2, vecs[idx].c1, vecs[idx].c0});
                check($sformatf("vec_E%0d_neg", e), neg,
                      ~{vecs[idx].c3, vecs[idx].c2, vecs[idx].c1, vecs[idx].c0});
                check($sformatf("vec_E%0d_flags", e), {22'd0, run_ack, busy, act, strb},
                      {22'd0, vecs[idx].ack, vecs[idx].busy, vecs[idx].act, vecs[idx].strb});
                idx++;
            end
        end

        // Abort while still starting: late phases never leave zero.
        do_reset();
        run_req = 1'b1;
        for (int e = 0; e <= 9; e++) tick();
        run_req = 1'b0;
        tick();
        check("abort_E10", {29'd0, run_ack, act[1:0]}, 32'b011);
        for (int e = 11; e <= 32; e++) begin
            tick();
            check($sformatf("abort_E%0d_p23", e), {16'd0, pos[31:16]}, 32'h0);
            if (e == 23) check("abort_E23_act", {28'd0, act}, 32'b0011);
            if (e == 24) check("abort_E24_act", {28'd0, act}, 32'b0010);
            if (e == 31) check("abort_E31_busy", {31'd0, busy}, 32'd1);
            if (e == 32) check("abort_E32", {27'd0, busy, act}, 32'h0);
        end

        // Asynchronous reset in the middle of a hold quarter, then a clean restart.
        do_reset();
        run_req = 1'b1;
        for (int e = 0; e <= 10; e++) tick();
        check("ares_hold", {24'd0, pos[7:0]}, 32'd255);
        #1 rst_n = 1'b0;
        #1;
        check("ares_pos", pos, 32'h0);
        check("ares_neg", neg, 32'hffff_ffff);
        check("ares_flags", {22'd0, run_ack, busy, act, strb}, 32'h0);
        rst_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            if (e == 0) check("restart_E0", {24'd0, pos[7:0]}, 32'd31);
            if (e == 7) check("restart_E7", {20'd0, strb, pos[7:0]}, 32'd255);
            if (e == 8) check("restart_E8", {16'd0, strb, 4'd0, pos[15:8]}, {16'd0, 4'b0001, 4'd0, 8'd31});
        end

        // Re-request during drain is held off until the sequencer is back to off.
        do_reset();
        run_req = 1'b1;
        for (int e = 0; e <= 39; e++) tick();
        run_req = 1'b0;
        tick();
        run_req = 1'b1;
        for (int e = 41; e <= 73; e++) begin
            tick();
            if (e == 41 || e == 60 || e == 71) check($sformatf("rereq_E%0d_busy", e), {31'd0, busy}, 32'd1);
            if (e == 50) check("rereq_E50_ack", {31'd0, run_ack}, 32'd0);
            if (e == 72) check("rereq_E72", {27'd0, busy, act}, 32'h0);
            if (e == 73) check("rereq_E73", {19'd0, busy, act, pos[7:0]}, {19'd0, 1'b1, 4'b0001, 8'd31});
        end

        // Randomized run/stop levels with occasional asynchronous resets.
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 7) == 0) begin
                #1 rst_n = 1'b0;
                model_reset();
                #1;
                check_model($sformatf("rnd_rst%0d", seg));
                rst_n = 1'b1;
            end
            req = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 90));
            for (int k = 0; k < len; k++) begin
                run_req = req;
                tick();
                model_step(req);
                check_model($sformatf("rnd_s%0d_k%0d", seg, k));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
